// File: rtl/soc_bus_ctrl_pkg.sv
// Shared types and constants for the CPU bus target: FSM states, decode classes and
// MMIO register offsets.
package soc_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StAccess,
      StDone
   } bus_state_e;

   typedef enum logic [1:0] {
      DecRam,
      DecMmio,
      DecUnmapped
   } decode_e;

   localparam logic [1:0] RegGpioOut = 2'd0;
   localparam logic [1:0] RegGpioIn  = 2'd1;
   localparam logic [1:0] RegStatus  = 2'd2;
   localparam logic [1:0] RegTick    = 2'd3;

endpackage

// File: rtl/soc_bus_ctrl_if.sv
// CPU four-phase read/write/done handshake bundle; the CPU is the master.
interface soc_bus_ctrl_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) ();

   logic [ADDR_W-1:0] bus_address_in;
   logic [DATA_W-1:0] bus_data_in;
   logic              bus_read;
   logic              bus_write;
   logic [DATA_W-1:0] bus_data_out;
   logic              bus_done;

   modport master (
      output bus_address_in,
      output bus_data_in,
      output bus_read,
      output bus_write,
      input  bus_data_out,
      input  bus_done
   );

   modport slave (
      input  bus_address_in,
      input  bus_data_in,
      input  bus_read,
      input  bus_write,
      output bus_data_out,
      output bus_done
   );

endinterface

// File: rtl/soc_ram.sv
// Single-port synchronous RAM, one-cycle read latency, write-first on a same-cycle write.
module soc_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/soc_bus_ctrl.sv
// CPU bus target: decodes RAM / MMIO / unmapped space, inserts programmable wait states
// and keeps a sticky error flag for decode and protocol errors.
module soc_bus_ctrl
   import soc_bus_ctrl_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       RAM_DEPTH   = 256,
   parameter logic [ADDR_W-1:0] IO_BASE     = 'hFF00,
   parameter int unsigned       WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   soc_bus_ctrl_if.slave     bus,
   output logic [DATA_W-1:0] gpio_out,
   input  logic [DATA_W-1:0] gpio_in,
   output logic              bus_error
);

   localparam int unsigned       RamAw    = $clog2(RAM_DEPTH);
   localparam logic [ADDR_W:0]   RamLimit = (ADDR_W+1)'(RAM_DEPTH);
   localparam logic [ADDR_W-1:0] IoLast   = IO_BASE + ADDR_W'(3);
   localparam logic [3:0]        WaitLast = 4'(WAIT_STATES - 1);

   bus_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rd_q;
   logic              wr_q;
   logic              conflict_q;
   logic [3:0]        cnt_q;
   logic              done_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] tick_q;
   logic [DATA_W-1:0] sync1_q;
   logic [DATA_W-1:0] gpio_sync_q;

   decode_e           dec;
   logic [1:0]        io_off;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] ram_rdata;
   logic [RamAw-1:0]  ram_addr;
   logic              ram_we;
   logic              err_set;
   logic              err_clr;

   assign bus.bus_done     = done_q;
   assign bus.bus_data_out = rdata_q;

   always_comb begin
      dec = DecUnmapped;
      if ({1'b0, addr_q} < RamLimit) begin
         dec = DecRam;
      end else if (addr_q >= IO_BASE && addr_q <= IoLast) begin
         dec = DecMmio;
      end
   end

   assign io_off = 2'(addr_q - IO_BASE);

   // Present the live address while idle so read data is ready by the ACCESS cycle.
   assign ram_addr = (state_q == StIdle) ? bus.bus_address_in[RamAw-1:0] : addr_q[RamAw-1:0];
   assign ram_we   = (state_q == StAccess) && wr_q && !conflict_q && (dec == DecRam) && !rst;

   assign err_set = conflict_q || (dec == DecUnmapped);
   assign err_clr = wr_q && !conflict_q && (dec == DecMmio) && (io_off == RegStatus) && wdata_q[0];

   always_comb begin
      rd_data = '1;
      unique case (dec)
         DecRam:  rd_data = ram_rdata;
         DecMmio: begin
            unique case (io_off)
               RegGpioOut: rd_data = gpio_out;
               RegGpioIn:  rd_data = gpio_sync_q;
               RegStatus:  rd_data = {{(DATA_W-1){1'b0}}, bus_error};
               RegTick:    rd_data = tick_q;
            endcase
         end
         default: rd_data = '1;
      endcase
   end

   soc_ram #(
      .DEPTH (RAM_DEPTH),
      .WIDTH (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         conflict_q <= 1'b0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         rdata_q    <= '0;
         gpio_out   <= '0;
         bus_error  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.bus_read || bus.bus_write) begin
                  addr_q     <= bus.bus_address_in;
                  wdata_q    <= bus.bus_data_in;
                  rd_q       <= bus.bus_read;
                  wr_q       <= bus.bus_write;
                  conflict_q <= bus.bus_read && bus.bus_write;
                  cnt_q      <= '0;
                  state_q    <= (WAIT_STATES > 0) ? StWait : StAccess;
               end
            end
            StWait: begin
               if (cnt_q == WaitLast) begin
                  state_q <= StAccess;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            StAccess: begin
               done_q  <= 1'b1;
               rdata_q <= conflict_q ? '1 : (rd_q ? rd_data : '0);
               if (wr_q && !conflict_q && dec == DecMmio && io_off == RegGpioOut) begin
                  gpio_out <= wdata_q;
               end
               // A newly raised error outranks a STATUS clear in the same access.
               if (err_set) begin
                  bus_error <= 1'b1;
               end else if (err_clr) begin
                  bus_error <= 1'b0;
               end
               state_q <= StDone;
            end
            StDone: begin
               if (!bus.bus_read && !bus.bus_write) begin
                  done_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q      <= '0;
         sync1_q     <= '0;
         gpio_sync_q <= '0;
      end else begin
         tick_q      <= tick_q + DATA_W'(1);
         sync1_q     <= gpio_in;
         gpio_sync_q <= sync1_q;
      end
   end

endmodule

// File: tb/tb_soc_bus_ctrl.sv
// Bench for soc_bus_ctrl: two instances (0 and 3 wait states) driven in lockstep,
// with a reference model feeding an expected-result queue.
module tb_soc_bus_ctrl;

   localparam logic [15:0] IoBase = 16'hFF00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] gpio_in = 8'h00;
   logic [7:0] gpio_out0, gpio_out3;
   logic       err0, err3;
   logic [7:0] cyc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      bit         chk_data;
      bit         is_tick;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] m_ram [256];
   logic [7:0] m_gpio;
   logic       m_err;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 8'd0;
      else     cyc <= cyc + 8'd1;
   end

   soc_bus_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus0 ();
   soc_bus_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus3 ();

   soc_bus_ctrl #(.WAIT_STATES(0)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus0),
      .gpio_out  (gpio_out0),
      .gpio_in   (gpio_in),
      .bus_error (err0)
   );

   soc_bus_ctrl #(.WAIT_STATES(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus3),
      .gpio_out  (gpio_out3),
      .gpio_in   (gpio_in),
      .bus_error (err3)
   );

   task automatic drive(bit rd, bit wr, logic [15:0] a, logic [7:0] d);
      bus0.bus_read = rd; bus0.bus_write = wr; bus0.bus_address_in = a; bus0.bus_data_in = d;
      bus3.bus_read = rd; bus3.bus_write = wr; bus3.bus_address_in = a; bus3.bus_data_in = d;
   endtask

   task automatic push_exp(bit rd, bit wr, logic [15:0] a, logic [7:0] d);
      exp_t        e;
      logic [15:0] off;
      e.chk_data = rd;
      e.is_tick  = 1'b0;
      e.data     = 8'hFF;
      off        = a - IoBase;
      if (rd && wr) begin
         m_err = 1'b1;
      end else if (a < 16'd256) begin
         if (wr) m_ram[a[7:0]] = d;
         else    e.data = m_ram[a[7:0]];
      end else if (a >= IoBase && a <= IoBase + 16'd3) begin
         case (off)
            16'd0:   if (wr) m_gpio = d; else e.data = m_gpio;
            16'd1:   e.data = gpio_in;
            16'd2:   if (wr) begin if (d[0]) m_err = 1'b0; end else e.data = {7'b0, m_err};
            default: e.is_tick = 1'b1;
         endcase
      end else begin
         m_err = 1'b1;
      end
      e.err = m_err;
      exp_q.push_back(e);
   endtask

   // Full handshake on both instances; optionally moves the address after it is sampled.
   task automatic xact(bit rd, bit wr, logic [15:0] a, logic [7:0] d, bit swap_addr);
      exp_t       e;
      int         k0 = 0;
      int         k3 = 0;
      logic [7:0] t0 = 8'h00;
      logic [7:0] t3 = 8'h00;
      logic [7:0] x0, x3;
      @(negedge clk);
      drive(rd, wr, a, d);
      push_exp(rd, wr, a, d);
      for (int k = 1; k <= 40 && (k0 == 0 || k3 == 0); k++) begin
         @(posedge clk); #1;
         if (k == 1 && swap_addr) drive(rd, wr, a ^ 16'h0004, d ^ 8'hFF);
         if (k0 == 0 && bus0.bus_done) begin k0 = k; t0 = cyc - 8'd1; end
         if (k3 == 0 && bus3.bus_done) begin k3 = k; t3 = cyc - 8'd1; end
      end
      e = exp_q.pop_front();
      checks += 2;
      if (k0 !== 2) begin errors++; $display("FAIL latency0 a=%h got %0d exp 2", a, k0); end
      if (k3 !== 5) begin errors++; $display("FAIL latency3 a=%h got %0d exp 5", a, k3); end
      if (e.chk_data) begin
         x0 = e.is_tick ? t0 : e.data;
         x3 = e.is_tick ? t3 : e.data;
         checks += 2;
         if (bus0.bus_data_out !== x0) begin
            errors++; $display("FAIL data0 a=%h got %h exp %h", a, bus0.bus_data_out, x0);
         end
         if (bus3.bus_data_out !== x3) begin
            errors++; $display("FAIL data3 a=%h got %h exp %h", a, bus3.bus_data_out, x3);
         end
      end
      checks += 2;
      if (err0 !== e.err) begin errors++; $display("FAIL err0 a=%h got %b exp %b", a, err0, e.err); end
      if (err3 !== e.err) begin errors++; $display("FAIL err3 a=%h got %b exp %b", a, err3, e.err); end
      @(posedge clk); #1;
      checks++;
      if (!(bus0.bus_done === 1'b1 && bus3.bus_done === 1'b1)) begin
         errors++; $display("FAIL done_hold a=%h got %b%b exp 11", a, bus0.bus_done, bus3.bus_done);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, a, d);
      @(posedge clk); #1;
      checks++;
      if (!(bus0.bus_done === 1'b0 && bus3.bus_done === 1'b0)) begin
         errors++; $display("FAIL done_clear a=%h got %b%b exp 00", a, bus0.bus_done, bus3.bus_done);
      end
   endtask

   task automatic check_gpio(string name);
      checks += 2;
      if (gpio_out0 !== m_gpio) begin
         errors++; $display("FAIL %s gpio_out0 got %h exp %h", name, gpio_out0, m_gpio);
      end
      if (gpio_out3 !== m_gpio) begin
         errors++; $display("FAIL %s gpio_out3 got %h exp %h", name, gpio_out3, m_gpio);
      end
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 16'h0000, 8'h00);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      m_gpio = 8'h00;
      m_err  = 1'b0;
      checks += 4;
      if (bus0.bus_done !== 1'b0 || bus3.bus_done !== 1'b0) begin
         errors++; $display("FAIL reset_done got %b%b exp 00", bus0.bus_done, bus3.bus_done);
      end
      if (bus0.bus_data_out !== 8'h00 || bus3.bus_data_out !== 8'h00) begin
         errors++; $display("FAIL reset_data got %h %h exp 00", bus0.bus_data_out, bus3.bus_data_out);
      end
      if (err0 !== 1'b0 || err3 !== 1'b0) begin
         errors++; $display("FAIL reset_err got %b%b exp 00", err0, err3);
      end
      if (gpio_out0 !== 8'h00 || gpio_out3 !== 8'h00) begin
         errors++; $display("FAIL reset_gpio got %h %h exp 00", gpio_out0, gpio_out3);
      end
   endtask

   task automatic test_ram_rw();
      xact(1'b0, 1'b1, 16'h0010, 8'h5A, 1'b0);
      xact(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0);
      xact(1'b0, 1'b1, 16'h00FF, 8'hA5, 1'b0);
      xact(1'b0, 1'b1, 16'h0000, 8'h3E, 1'b0);
      xact(1'b1, 1'b0, 16'h00FF, 8'h00, 1'b0);
      xact(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
   endtask

   task automatic test_unmapped_status();
      xact(1'b1, 1'b0, 16'h8000, 8'h00, 1'b0);
      xact(1'b0, 1'b1, IoBase + 16'd2, 8'h01, 1'b0);
      xact(1'b1, 1'b0, IoBase + 16'd2, 8'h00, 1'b0);
      xact(1'b1, 1'b0, 16'h0100, 8'h00, 1'b0);
      xact(1'b0, 1'b1, IoBase + 16'd2, 8'hFE, 1'b0);
      xact(1'b1, 1'b0, IoBase + 16'd2, 8'h00, 1'b0);
      xact(1'b0, 1'b1, IoBase + 16'd2, 8'h01, 1'b0);
      xact(1'b0, 1'b1, IoBase + 16'd4, 8'h66, 1'b0);
      xact(1'b0, 1'b1, IoBase + 16'd2, 8'h01, 1'b0);
   endtask

   task automatic test_gpio();
      xact(1'b0, 1'b1, IoBase, 8'hC3, 1'b0);
      check_gpio("gpio_write");
      gpio_in = 8'h3C;
      repeat (3) @(posedge clk);
      xact(1'b1, 1'b0, IoBase + 16'd1, 8'h00, 1'b0);
      xact(1'b0, 1'b1, IoBase + 16'd1, 8'h55, 1'b0);
      xact(1'b1, 1'b0, IoBase, 8'h00, 1'b0);
      xact(1'b1, 1'b0, IoBase + 16'd3, 8'h00, 1'b0);
      check_gpio("gpio_hold");
   endtask

   task automatic test_conflict();
      xact(1'b1, 1'b1, 16'h0010, 8'h99, 1'b0);
      xact(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0);
      xact(1'b0, 1'b1, IoBase + 16'd2, 8'h01, 1'b0);
      xact(1'b0, 1'b1, 16'h0034, 8'h11, 1'b0);
      xact(1'b0, 1'b1, 16'h0030, 8'h77, 1'b1);
      xact(1'b1, 1'b0, 16'h0030, 8'h00, 1'b1);
      xact(1'b1, 1'b0, 16'h0034, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid();
      xact(1'b0, 1'b1, 16'h0020, 8'h11, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h0020, 8'h77);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      m_gpio = 8'h00;
      m_err  = 1'b0;
      checks++;
      if (bus0.bus_done !== 1'b0 || bus3.bus_done !== 1'b0) begin
         errors++; $display("FAIL midrst_done got %b%b exp 00", bus0.bus_done, bus3.bus_done);
      end
      check_gpio("midrst");
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 8'h00);
      xact(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0);
      xact(1'b1, 1'b0, IoBase + 16'd2, 8'h00, 1'b0);
   endtask

   initial begin
      test_reset();
      test_ram_rw();
      test_unmapped_status();
      test_gpio();
      test_conflict();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
